// File: rtl/hdmi_ctrl_pkg.sv
// hdmi_ctrl_pkg: shared types and defaults for the HDMI channel controller
package hdmi_ctrl_pkg;
  localparam int NUM_CHANNELS_MAX = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int AUTO_FRAMES_DEFAULT = 120;
  typedef logic [$clog2(NUM_CHANNELS_MAX)-1:0] channel_t;
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} ctrl_state_t;
  function automatic channel_t wrap_step(channel_t c, logic up, int n);
    if (up) return (c == channel_t'(n - 1)) ? channel_t'(0) : c + 2'd1;
    return (c == 2'd0) ? channel_t'(n - 1) : c - 2'd1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse
module btn_debounce
  import hdmi_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        level <= ~level;
        press <= ~level;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hdmi_channel_ctrl.sv
// hdmi_channel_ctrl: button-driven channel select, committed only at frame boundaries
// Optional idle auto-advance enabled by defining CHANNEL_AUTO_SCAN_EN.
module hdmi_channel_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_CHANNELS = 4,
  parameter int AUTO_FRAMES = AUTO_FRAMES_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     btn_next,
  input  logic     btn_prev,
  input  logic     frame_start,
  input  logic     data_en,
  output channel_t channel_select,
  output logic     pending,
  output logic     change_pulse
);
  logic nx, pv, frame_ok, auto_adv;
  ctrl_state_t state;
  channel_t target, commit_val, t_nxt, cs_nxt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .raw(btn_next), .press(nx));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .rst(rst), .raw(btn_prev), .press(pv));
  assign frame_ok = frame_start & ~data_en;
`ifdef CHANNEL_AUTO_SCAN_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic [FW-1:0] fcnt;
  assign auto_adv = (fcnt == FW'(AUTO_FRAMES)) && state == IDLE && !(nx | pv);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fcnt <= '0;
    else if (nx | pv | auto_adv) fcnt <= '0;
    else if (frame_ok && fcnt != FW'(AUTO_FRAMES)) fcnt <= fcnt + 1'b1;
  end
`else
  assign auto_adv = AUTO_FRAMES < 0;
`endif
  always_comb begin
    t_nxt = ((nx ^ pv) | auto_adv) ? wrap_step(target, ~pv, NUM_CHANNELS) : target;
    cs_nxt = (state == COMMIT) ? commit_val : channel_select;
  end
  // commit_val freezes the pre-event target so a same-cycle press waits a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      target <= '0;
      commit_val <= '0;
      channel_select <= '0;
      pending <= 1'b0;
      change_pulse <= 1'b0;
    end else begin
      target <= t_nxt;
      channel_select <= cs_nxt;
      pending <= t_nxt != cs_nxt;
      change_pulse <= state == COMMIT;
      case (state)
        IDLE: if (t_nxt != channel_select) state <= PENDING;
        PENDING:
          if (frame_ok) begin
            state <= COMMIT;
            commit_val <= target;
          end else if (t_nxt == channel_select) state <= IDLE;
        COMMIT: state <= (t_nxt != commit_val) ? PENDING : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_channel_ctrl.sv
// tb_hdmi_channel_ctrl: vector table, directed corner sequences and randomized model check
module tb_hdmi_channel_ctrl;
  localparam int D = 8;
  localparam int N = 4;
  localparam int T = 3000;
  logic clk = 0, rst = 0, btn_next = 0, btn_prev = 0, frame_start = 0, data_en = 0;
  logic [1:0] channel_select;
  logic pending, change_pulse;
  int total = 0, bad = 0, pulses = 0, base;

  hdmi_channel_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_CHANNELS(N), .AUTO_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .frame_start(frame_start), .data_en(data_en),
    .channel_select(channel_select), .pending(pending), .change_pulse(change_pulse)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (change_pulse === 1'b1) pulses++;

  typedef struct {
    string name;
    logic [3:0][2:0] ops;
    int exp_cs;
    int exp_pulses;
  } vec_t;
  vec_t vecs[10];

  logic rn[T], rp[T], evn[T], evp[T], fs[T], de[T];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 0; btn_next = 0; btn_prev = 0; frame_start = 0; data_en = 0;
    repeat (3) step();
    rst = 1;
    step();
  endtask

  task automatic press(input logic n, input logic p, input int len);
    btn_next = n; btn_prev = p;
    repeat (len) step();
    btn_next = 0; btn_prev = 0;
    repeat (D + 6) step();
  endtask

  task automatic frame();
    frame_start = 1; data_en = 0;
    step();
    frame_start = 0;
    repeat (4) step();
  endtask

  task automatic do_op(input logic [2:0] op);
    case (op)
      3'd1: press(1, 0, D + 4);
      3'd2: press(0, 1, D + 4);
      3'd3: press(1, 1, D + 4);
      3'd4: begin
        for (int i = 0; i < 30; i++) begin
          btn_next = ((i / 3) % 2 == 0);
          step();
        end
        btn_next = 0;
        repeat (D + 6) step();
      end
      3'd5: press(1, 0, D);
      3'd6: press(1, 0, D - 1);
      default: ;
    endcase
  endtask

  task automatic gen_btn(input bit p);
    int t, len;
    t = 5;
    while (t < T - 60) begin
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 30);
      for (int i = 0; i < len; i++) begin
        if (p) rp[t + i] = 1; else rn[t + i] = 1;
      end
      if (len >= D) begin
        if (p) evp[t + D + 2] = 1; else evn[t + D + 2] = 1;
      end
      t += len + $urandom_range(D + 4, 60);
    end
  endtask

  initial begin
    vecs[0] = '{name: "next",       ops: {3'd0, 3'd0, 3'd0, 3'd1}, exp_cs: 1, exp_pulses: 1};
    vecs[1] = '{name: "prev_wrap",  ops: {3'd0, 3'd0, 3'd0, 3'd2}, exp_cs: 3, exp_pulses: 1};
    vecs[2] = '{name: "accum",      ops: {3'd2, 3'd1, 3'd1, 3'd2}, exp_cs: 0, exp_pulses: 0};
    vecs[3] = '{name: "three_next", ops: {3'd0, 3'd1, 3'd1, 3'd1}, exp_cs: 3, exp_pulses: 1};
    vecs[4] = '{name: "next_wrap",  ops: {3'd1, 3'd1, 3'd1, 3'd1}, exp_cs: 0, exp_pulses: 0};
    vecs[5] = '{name: "bounce",     ops: {3'd0, 3'd0, 3'd0, 3'd4}, exp_cs: 0, exp_pulses: 0};
    vecs[6] = '{name: "both",       ops: {3'd0, 3'd0, 3'd0, 3'd3}, exp_cs: 0, exp_pulses: 0};
    vecs[7] = '{name: "exact_len",  ops: {3'd0, 3'd0, 3'd0, 3'd5}, exp_cs: 1, exp_pulses: 1};
    vecs[8] = '{name: "short_len",  ops: {3'd0, 3'd0, 3'd0, 3'd6}, exp_cs: 0, exp_pulses: 0};
    vecs[9] = '{name: "two_prev",   ops: {3'd0, 3'd0, 3'd2, 3'd2}, exp_cs: 2, exp_pulses: 1};

    do_reset();
    chk("reset_cs", channel_select, 0);
    chk("reset_pending", pending, 0);
    chk("reset_pulse", change_pulse, 0);

    for (int r = 0; r < 10; r++) begin
      do_reset();
      base = pulses;
      for (int i = 0; i < 4; i++) do_op(vecs[r].ops[i]);
      chk({vecs[r].name, "_pend_pre"}, pending, (vecs[r].exp_cs != 0) ? 1 : 0);
      frame();
      chk({vecs[r].name, "_cs"}, channel_select, vecs[r].exp_cs);
      chk({vecs[r].name, "_pulses"}, pulses - base, vecs[r].exp_pulses);
      chk({vecs[r].name, "_pend"}, pending, 0);
    end

    // press latency, commit latency and single-cycle change pulse
    do_reset();
    btn_next = 1;
    repeat (D + 2) step();
    chk("lat_pend_early", pending, 0);
    step();
    chk("lat_pend", pending, 1);
    repeat (20 - (D + 3)) step();
    btn_next = 0;
    repeat (D + 6) step();
    frame_start = 1;
    step();
    frame_start = 0;
    chk("commit_cs_hold", channel_select, 0);
    chk("commit_pulse_early", change_pulse, 0);
    step();
    chk("commit_cs", channel_select, 1);
    chk("commit_pulse", change_pulse, 1);
    step();
    chk("commit_pulse_end", change_pulse, 0);
    chk("commit_pend", pending, 0);

    // frame_start during active video must not commit
    press(0, 1, D + 4);
    base = pulses;
    frame_start = 1; data_en = 1;
    step();
    frame_start = 0; data_en = 0;
    repeat (3) step();
    chk("fault_cs", channel_select, 1);
    chk("fault_pend", pending, 1);
    chk("fault_pulses", pulses - base, 0);
    frame();
    chk("fault_recover_cs", channel_select, 0);

    // asynchronous reset mid-operation
    do_reset();
    press(1, 0, D + 4);
    press(1, 0, D + 4);
    frame();
    press(1, 0, D + 4);
    chk("mid_cs", channel_select, 2);
    chk("mid_pend", pending, 1);
    #2 rst = 0;
    #1;
    chk("async_cs", channel_select, 0);
    chk("async_pend", pending, 0);
    chk("async_pulse", change_pulse, 0);
    repeat (2) step();
    rst = 1;
    step();
    base = pulses;
    frame();
    chk("post_rst_pulses", pulses - base, 0);
    chk("post_rst_cs", channel_select, 0);

`ifdef CHANNEL_AUTO_SCAN_EN
    do_reset();
    repeat (3) frame();
    chk("auto_pend", pending, 1);
    chk("auto_cs_hold", channel_select, 0);
    frame();
    chk("auto_cs", channel_select, 1);
`else
    // randomized run against a frame-level model
    for (int t = 0; t < T; t++) begin
      rn[t] = 0; rp[t] = 0; evn[t] = 0; evp[t] = 0; fs[t] = 0;
      de[t] = 1'($urandom_range(0, 1));
    end
    gen_btn(0);
    gen_btn(1);
    for (int t = 3 + $urandom_range(10, 50); t < T - 3; t += $urandom_range(10, 50)) begin
      fs[t] = 1;
      de[t] = ($urandom_range(0, 3) == 0);
    end
    do_reset();
    begin
      int m_target, m_cs, m_sval, old, d;
      bit m_sched, m_pulse;
      m_target = 0; m_cs = 0; m_sval = 0; m_sched = 0;
      for (int t = 0; t < T; t++) begin
        btn_next = rn[t]; btn_prev = rp[t]; frame_start = fs[t]; data_en = de[t];
        step();
        d = (evn[t] && !evp[t]) ? 1 : (evp[t] && !evn[t]) ? -1 : 0;
        old = m_target;
        m_target = (m_target + d + N) % N;
        m_pulse = 0;
        if (m_sched) begin
          m_cs = m_sval;
          m_pulse = 1;
          m_sched = 0;
        end else if (fs[t] && !de[t] && old != m_cs) begin
          m_sched = 1;
          m_sval = old;
        end
        chk("rand", {channel_select, pending, change_pulse},
            {m_cs[1:0], (m_target != m_cs) ? 1'b1 : 1'b0, m_pulse});
      end
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
